// File: rtl/div_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// Produces one quotient bit per clock, MSB first, and pulses done when the result registers load.
`timescale 1ns/1ps
module div_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       ready,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  work_q, work_d;
    logic [3:0]  dvs_q, dvs_d;
    logic [3:0]  part_q, part_d;
    logic [7:0]  quo_q, quo_d;
    logic [3:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    // work_q starts as the dividend; quotient bits enter at the LSB as dividend bits leave at the MSB.
    logic [4:0]  shifted;
    logic        fits;
    logic [3:0]  diff;
    logic [7:0]  work_shift;

    assign shifted    = {part_q, work_q[7]};
    assign fits       = (shifted >= {1'b0, dvs_q});
    // When fits is set the difference is below the divisor, so four bits hold it exactly.
    assign diff       = shifted[3:0] - dvs_q;
    assign work_shift = {work_q[6:0], fits};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d  = divisor;
                    work_d = dividend;
                    part_d = 4'd0;
                    cnt_d  = 3'd0;
                    if (divisor == 4'd0) begin
                        state_d = DONE;
                        quo_d   = 8'hFF;
                        rem_d   = 4'd0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                work_d = work_shift;
                part_d = fits ? diff : shifted[3:0];
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    quo_d   = work_shift;
                    rem_d   = fits ? diff : shifted[3:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs follow the next state so they are registered yet aligned with it.
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            work_q  <= 8'd0;
            dvs_q   <= 4'd0;
            part_q  <= 4'd0;
            quo_q   <= 8'd0;
            rem_q   <= 4'd0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed and exhaustive bench for div_seq; expected results are queued at stimulus time
// and popped when done is observed.
`timescale 1ns/1ps
module tb_div_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   fails    = 0;
    int   done_cnt = 0;

    div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 8'hFF;
            e.r = 4'd0;
            e.z = 1'b1;
        end else begin
            e.q = a / {4'd0, b};
            e.r = 4'(a % {4'd0, b});
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(32'(ready), 32'd1, "ready_before_start");
    endtask

    // Called just after the accept edge; counts cycles until done and cycles with ready low.
    task automatic wait_done(output int lat, output int rlow);
        lat  = 0;
        rlow = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (ready !== 1'b1) rlow++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check(32'd1, 32'd0, {tag, "_scoreboard_empty"});
        end else begin
            e = sb.pop_front();
            check(32'(quotient), 32'(e.q), {tag, "_quotient"});
            check(32'(remainder), 32'(e.r), {tag, "_remainder"});
            check(32'(dbz), 32'(e.z), {tag, "_dbz"});
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input string tag);
        int lat;
        int rlow;
        wait_ready();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        wait_done(lat, rlow);
        check(32'(lat), (b == 4'd0) ? 32'd1 : 32'd9, {tag, "_latency"});
        check(32'(rlow), (b == 4'd0) ? 32'd1 : 32'd9, {tag, "_ready_low"});
        compare_result(tag);
    endtask

    initial begin
        int lat;
        int rlow;
        int d0;
        int nexp;
        exp_t e;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;

        // Reset state, with start held high to show it is ignored.
        #12;
        start = 1'b1;
        #11;
        check(32'(ready), 32'd1, "reset_ready");
        check(32'(done), 32'd0, "reset_done");
        check(32'(quotient), 32'd0, "reset_quotient");
        check(32'(remainder), 32'd0, "reset_remainder");
        check(32'(dbz), 32'd0, "reset_dbz");
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b1;

        run_op(8'd42, 4'd6, "op_42_6");
        run_op(8'd54, 4'd6, "op_54_6");
        run_op(8'd40, 4'd8, "op_40_8");
        run_op(8'd200, 4'd7, "op_200_7");
        run_op(8'd255, 4'd1, "op_255_1");
        run_op(8'd17, 4'd0, "op_17_0");
        run_op(8'd17, 4'd5, "op_17_5");
        run_op(8'd0, 4'd15, "op_0_15");
        run_op(8'd255, 4'd15, "op_255_15");

        // A start and new operands during CALC must not disturb the running operation.
        wait_ready();
        d0       = done_cnt;
        dividend = 8'd100;
        divisor  = 4'd3;
        start    = 1'b1;
        sb.push_back(model(8'd100, 4'd3));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd9;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd250;
        divisor  = 4'd2;
        lat = 3;
        while (lat < 30 && done !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        check(32'(lat), 32'd9, "ignore_start_latency");
        compare_result("ignore_start");
        repeat (12) @(negedge clk);
        check(32'(done_cnt - d0), 32'd1, "ignore_start_done_count");

        // Asynchronous reset mid-CALC aborts with no done pulse.
        wait_ready();
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        start = 1'b1;
        #1;
        check(32'(quotient), 32'd0, "async_reset_quotient");
        check(32'(remainder), 32'd0, "async_reset_remainder");
        check(32'(dbz), 32'd0, "async_reset_dbz");
        check(32'(ready), 32'd1, "async_reset_ready");
        check(32'(done), 32'd0, "async_reset_done");
        repeat (3) @(negedge clk);
        check(32'(ready), 32'd1, "reset_hold_ready");
        check(32'(quotient), 32'd0, "reset_hold_quotient");
        start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check(32'(done_cnt - d0), 32'd0, "reset_abort_no_done");
        run_op(8'd6, 4'd4, "after_reset_6_4");

        // start held high: a new operation every 10 cycles.
        wait_ready();
        dividend = 8'd77;
        divisor  = 4'd5;
        start    = 1'b1;
        sb.push_back(model(8'd77, 4'd5));
        nexp = 9;
        for (int n = 1; n <= 29; n++) begin
            @(negedge clk);
            if (n == 10 || n == 20) sb.push_back(model(8'd77, 4'd5));
            if (n == 29) start = 1'b0;
            if (done === 1'b1) begin
                check(32'(n), 32'(nexp), "back_to_back_spacing");
                compare_result("back_to_back");
                nexp += 10;
            end
        end
        check(32'(nexp), 32'd39, "back_to_back_done_count");

        // Exhaustive sweep of every operand pair.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(8'(a), 4'(b), "sweep");
            end
        end

        check(32'(sb.size()), 32'd0, "scoreboard_drained");
        e = model(8'd0, 4'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
